// File: rtl/dsp_capture_pkg.sv
// dsp_capture_pkg: shared FSM state codes, trigger-mode codes and trigger select helper.
// Used by dsp_capture; no ports.
package dsp_capture_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_POST = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;
   localparam logic [1:0] TRIG_EXT    = 2'd0;
   localparam logic [1:0] TRIG_MATCH  = 2'd1;
   localparam logic [1:0] TRIG_EITHER = 2'd2;
   localparam logic [1:0] TRIG_IMM    = 2'd3;
   function automatic logic trig_sel(input logic [1:0] mode, input logic ext, input logic match);
      return mode == TRIG_EXT ? ext : mode == TRIG_MATCH ? match : mode == TRIG_EITHER ? (ext | match) : 1'b1;
   endfunction
endpackage

// File: rtl/dsp_capture_ram.sv
// capture_ram: simple dual-port RAM, DW x 2^AW, one write port, registered read port.
// Ports: clk, rst (clears only the read register), we/waddr/wdata write, raddr/rdata read (1-cycle latency).
module capture_ram #(
   parameter int DW = 64,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata <= '0;
      else rdata <= mem[raddr];
   end
endmodule

// File: rtl/dsp_capture.sv
// dsp_capture: circular capture buffer with pre-trigger depth and ext/match/immediate trigger.
// Ports: clk/rst (async active-high); probe/probe_valid sample input; arm/abort control pulses;
// ext_trig/trig_mode/trig_mask/trig_value trigger setup; pretrig pre-trigger depth;
// rd_addr/rd_data window readout (1-cycle latency); state/done/trig_addr status.
module dsp_capture
   import dsp_capture_pkg::*;
#(
   parameter int DW = 64,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] probe,
   input  logic          probe_valid,
   input  logic          arm,
   input  logic          abort,
   input  logic          ext_trig,
   input  logic [1:0]    trig_mode,
   input  logic [DW-1:0] trig_mask,
   input  logic [DW-1:0] trig_value,
   input  logic [AW-1:0] pretrig,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [2:0]    state,
   output logic          done,
   output logic [AW-1:0] trig_addr
);
   logic [2:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, post_q, post_d, pre_q, pre_d, trig_addr_q, trig_addr_d;
   logic          done_q, done_d, we, hit;
   // pretrig is AW bits wide, so it can never exceed DEPTH-1 and needs no explicit clamp
   assign hit = probe_valid & trig_sel(trig_mode, ext_trig, ((probe ^ trig_value) & trig_mask) == '0);
   always_comb begin
      state_d = state_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d = cnt_q;
      post_d = post_q;
      pre_d = pre_q;
      trig_addr_d = trig_addr_q;
      done_d = done_q;
      we = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         done_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (arm) begin
               wr_ptr_d = '0;
               cnt_d = '0;
               pre_d = pretrig;
               done_d = 1'b0;
               state_d = pretrig != '0 ? ST_PRE : ST_WAIT;
            end
            ST_PRE: if (probe_valid) begin
               we = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               state_d = cnt_d == pre_q ? ST_WAIT : ST_PRE;
            end
            ST_WAIT: if (probe_valid) begin
               we = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (hit) begin
                  trig_addr_d = wr_ptr_q;
                  // samples after the trigger fill the rest of the DEPTH window
                  post_d = '1 - pre_q;
                  done_d = post_d == '0;
                  state_d = post_d == '0 ? ST_DONE : ST_POST;
               end
            end
            ST_POST: if (probe_valid) begin
               we = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               post_d = post_q - 1'b1;
               done_d = post_d == '0;
               state_d = post_d == '0 ? ST_DONE : ST_POST;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_ptr_q <= '0;
         cnt_q <= '0;
         post_q <= '0;
         pre_q <= '0;
         trig_addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q <= cnt_d;
         post_q <= post_d;
         pre_q <= pre_d;
         trig_addr_q <= trig_addr_d;
         done_q <= done_d;
      end
   end
   capture_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(wr_ptr_q),
      .wdata(probe),
      // oldest captured sample sits pre_q entries before the trigger
      .raddr(trig_addr_q - pre_q + rd_addr),
      .rdata(rd_data)
   );
   assign state = state_q;
   assign done = done_q;
   assign trig_addr = trig_addr_q;
endmodule

// File: tb/tb_dsp_capture.sv
// tb_dsp_capture: directed self-checking bench for dsp_capture (DW=16, AW=4).
module tb_dsp_capture;
   localparam int DW = 16;
   localparam int AW = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [DW-1:0] probe = '0, trig_mask = '0, trig_value = '0, rd_data;
   logic probe_valid = 1'b0, arm = 1'b0, abort = 1'b0, ext_trig = 1'b0, done;
   logic [1:0] trig_mode = 2'd0;
   logic [AW-1:0] pretrig = '0, rd_addr = '0, trig_addr;
   logic [2:0] state;
   int compared = 0, mismatched = 0;
   logic dec = 1'b0;
   logic [DW-1:0] ext_at = 16'h7777, done_probe;

   dsp_capture #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .probe(probe), .probe_valid(probe_valid), .arm(arm), .abort(abort),
      .ext_trig(ext_trig), .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
      .pretrig(pretrig), .rd_addr(rd_addr), .rd_data(rd_data), .state(state), .done(done),
      .trig_addr(trig_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_probe(input logic [DW-1:0] v);
      probe = v;
      probe_valid = dec ? ~v[0] : 1'b1;
      ext_trig = v == ext_at;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      set_probe(probe + 16'd1);
   endtask

   task automatic arm_at(input logic [AW-1:0] pt, input logic [1:0] m, input logic [DW-1:0] msk,
                         input logic [DW-1:0] val, input logic [DW-1:0] first);
      pretrig = pt;
      trig_mode = m;
      trig_mask = msk;
      trig_value = val;
      set_probe(first - 16'd1);
      arm = 1'b1;
      tick;
      arm = 1'b0;
   endtask

   task automatic wait_done;
      int n = 0;
      while (!done && n < 64) begin
         tick;
         n++;
      end
      check("done_reached", {15'd0, done}, 16'd1);
      done_probe = probe;
   endtask

   task automatic read_lin(input string tag, input logic [DW-1:0] base, input logic [DW-1:0] stp);
      logic [DW-1:0] e;
      for (int i = 0; i < 16; i++) begin
         rd_addr = AW'(i);
         if (i > 0) begin
            e = base + stp * DW'(i - 1);
            check({tag, "_latency"}, rd_data, e);
         end
         tick;
         e = base + stp * DW'(i);
         check({tag, "_rd"}, rd_data, e);
      end
   endtask

   task automatic run_s1(input string tag, input logic [DW-1:0] f);
      arm_at(4'd4, 2'd1, 16'hFFFF, f + 16'h10, f);
      wait_done;
      check({tag, "_trig_addr"}, {12'd0, trig_addr}, 16'd0);
      check({tag, "_done_after"}, done_probe, f + 16'h1C);
      read_lin(tag, f + 16'h0C, 16'd1);
   endtask

   initial begin
      #2;
      check("reset_state", {13'd0, state}, 16'd0);
      check("reset_done", {15'd0, done}, 16'd0);
      check("reset_trig_addr", {12'd0, trig_addr}, 16'd0);
      check("reset_rd_data", rd_data, 16'd0);
      #20 rst = 1'b0;
      // match trigger with 4 pre-trigger samples
      run_s1("match", 16'h0000);
      // immediate trigger, no pre-trigger
      arm_at(4'd0, 2'd3, 16'h0000, 16'h0000, 16'h0005);
      check("imm_state_wait", {13'd0, state}, 16'd2);
      tick;
      check("imm_state_post", {13'd0, state}, 16'd3);
      wait_done;
      check("imm_state_done", {13'd0, state}, 16'd4);
      check("imm_trig_addr", {12'd0, trig_addr}, 16'd0);
      read_lin("imm", 16'h0005, 16'd1);
      // matches during PRE are ignored
      arm_at(4'd8, 2'd1, 16'h000F, 16'h0003, 16'h0000);
      wait_done;
      check("pre_trig_addr", {12'd0, trig_addr}, 16'd3);
      check("pre_done_after", done_probe, 16'h001B);
      read_lin("pre", 16'h000B, 16'd1);
      // decimated capture, external trigger at ramp 20
      dec = 1'b1;
      ext_at = 16'd20;
      arm_at(4'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000);
      wait_done;
      check("dec_trig_addr", {12'd0, trig_addr}, 16'd10);
      read_lin("dec", 16'd16, 16'd2);
      dec = 1'b0;
      ext_at = 16'h7777;
      // abort during POST, then arm+abort together from IDLE
      arm_at(4'd0, 2'd3, 16'h0000, 16'h0000, 16'h0040);
      tick;
      check("abort_in_post", {13'd0, state}, 16'd3);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_state", {13'd0, state}, 16'd0);
      check("abort_done", {15'd0, done}, 16'd0);
      arm = 1'b1;
      abort = 1'b1;
      tick;
      arm = 1'b0;
      abort = 1'b0;
      check("arm_abort_state", {13'd0, state}, 16'd0);
      run_s1("rearm", 16'h0100);
      // asynchronous reset in WAIT between clock edges
      arm_at(4'd4, 2'd1, 16'hFFFF, 16'h0010, 16'h0000);
      repeat (6) tick;
      check("rst_in_wait", {13'd0, state}, 16'd2);
      #3 rst = 1'b1;
      #1;
      check("async_rst_state", {13'd0, state}, 16'd0);
      check("async_rst_done", {15'd0, done}, 16'd0);
      check("async_rst_rd_data", rd_data, 16'd0);
      check("async_rst_trig_addr", {12'd0, trig_addr}, 16'd0);
      rst = 1'b0;
      tick;
      run_s1("post_rst", 16'h0200);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/dsp_capture.md
Name: dsp_capture

Overview:
- Synthesizable, parametrised in-fabric capture buffer for DSP debug signals: a generalised successor to a fixed-probe ILA stub.
- Records a DW-bit probe word into a 2^AW-deep circular RAM, with a programmable pre-trigger depth.
- Triggers from an external strobe, a masked value compare, or immediately.
- Capture is readable over a simple address/data port once done. Sits beside the DSP chain in the zcu216 top and is driven by register-bank controls.

Parameters:
- DW, 64, probe/sample width in bits.
- AW, 10, address width; buffer depth DEPTH = 2^AW samples.

Ports:
- clk  in  1  capture and readout clock.
- rst  in  1  asynchronous active-high reset.
- probe  in  DW  sample data.
- probe_valid  in  1  sample enable; only valid cycles are stored or tested for trigger.
- arm  in  1  single-cycle start pulse.
- abort  in  1  single-cycle cancel pulse.
- ext_trig  in  1  external trigger, level-sampled.
- trig_mode  in  2  0=ext, 1=match, 2=ext OR match, 3=immediate.
- trig_mask  in  DW  compare mask.
- trig_value  in  DW  compare value.
- pretrig  in  AW  number of pre-trigger samples; values above DEPTH-1 are clamped to DEPTH-1.
- rd_addr  in  AW  read index, relative to the oldest captured sample.
- rd_data  out  DW  read data.
- state  out  3  FSM state code.
- done  out  1  capture complete.
- trig_addr  out  AW  physical RAM address of the trigger sample.

Behaviour:
- Reset, asynchronous: state=IDLE(0), done=0, trig_addr=0, rd_data=0, wr_ptr=0, all counters 0.
- States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- match = ((probe ^ trig_value) & trig_mask) == 0. mask=0 always matches.
- hit = probe_valid & (selected condition). Mode 3: hit = probe_valid.
- IDLE:
  - On arm: wr_ptr<=0, cnt<=0.
  - Next state is PRE if clamped pretrig>0, else WAIT.
  - The arm cycle itself writes nothing.
- PRE:
  - Each valid sample is written at wr_ptr; wr_ptr and cnt increment.
  - Triggers are ignored.
  - When cnt reaches pretrig, go to WAIT; the transition happens on the write of the pretrig-th sample.
- WAIT:
  - Valid samples are written continuously; wr_ptr wraps modulo DEPTH, overwriting the oldest samples.
  - On hit: the sample is written, trig_addr<=wr_ptr, post counter loaded with DEPTH-1-pretrig.
  - If that load is 0, go directly to DONE; otherwise go to POST.
- POST: each valid sample is written and the post counter decrements; on reaching 0, go to DONE.
- DONE:
  - done=1, writes stop.
  - Captured window = DEPTH samples, oldest at physical start = trig_addr - pretrig (mod DEPTH).
  - arm re-enters the IDLE arm path in the same cycle (done<=0).
- Readout:
  - Physical address = start + rd_addr (mod DEPTH).
  - rd_data is registered with 1-cycle latency.
  - rd_addr = pretrig returns the trigger sample.
  - Reads in states other than DONE return raw RAM contents with no coherency guarantee.
- arm in PRE/WAIT/POST is ignored.
- abort in any state goes to IDLE next cycle, with done<=0.
- abort and arm together: abort wins, stays IDLE.
- Changing pretrig/trig_* while not IDLE is unsupported; pretrig is latched at arm.
- rst mid-capture immediately forces the reset values; RAM contents are undefined afterwards.
- All pointer arithmetic is AW-bit unsigned, wrap-around intended.

Decomposition:
- dsp_capture_pkg: state codes (IDLE..DONE), trig_mode constants (TRIG_EXT, TRIG_MATCH, TRIG_EITHER, TRIG_IMM).
- Sub-module capture_ram: simple dual-port RAM, DW x 2^AW, one write port, registered read port, no reset on the array.

Test Plan:
All scenarios use DW=16, AW=4 (DEPTH=16); probe is a ramp incrementing every cycle unless stated.
- Match trigger, pretrig=4: mode=1, mask=FFFF, value=0x0010, valid=1, arm in the cycle before ramp=0 -> done asserts after the ramp=0x1B sample is written; trig_addr=0; rd_addr 0..15 returns 0x0C..0x1B, 1-cycle latency.
- Immediate, no pre-trigger: pretrig=0, mode=3, arm in the cycle before ramp=5 -> state IDLE->WAIT->POST->DONE; rd_addr 0 returns 5, rd_addr 15 returns 0x14; trig_addr=0.
- Pre-trigger masking: pretrig=8, mode=1, mask=0x000F, value=0x3, arm before ramp=0 -> match at 3 ignored (PRE), trigger at 0x13; rd 8=0x13, rd 0=0x0B, rd 15=0x1A.
- Decimation: probe_valid high on even ramp values only, pretrig=2, mode=0, ext_trig pulsed with ramp=20 -> only even samples stored; rd 2=20, rd 0=16, rd 15=46.
- Abort: abort in POST -> next cycle state=0, done=0; arm+abort in the same cycle from IDLE -> state stays 0; a subsequent arm captures normally.
- Async reset: rst asserted mid-WAIT between clock edges -> state=0, done=0, rd_data=0 before the next edge; after release, arm behaves as in the first scenario.
